// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int MAX_WIDTH = 32;

    // Conditional two's-complement negate: the magnitude of a negative value,
    // or the re-signed form of a magnitude. Callers keep the low WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] twos_mag(input logic [MAX_WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract |B|.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   p,
    input  logic             dbit,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             unused_msb;

    // The extra top bit makes the trial's sign bit a clean "T < 0" indicator.
    always_comb begin
        shifted = {p, dbit};
        trial   = shifted - {2'b00, b};
        q_bit   = ~trial[WIDTH+1];
        p_next  = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

    assign unused_msb = shifted[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (unsigned/signed) with valid/ready on both sides.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output div_state_t       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE.
    localparam int CW = $clog2(WIDTH);

    div_state_t           state, state_next;
    logic [CW-1:0]        cnt;
    logic [WIDTH:0]       p, p_step;
    logic [WIDTH-1:0]     dq;
    logic [WIDTH-1:0]     b_mag;
    logic                 q_bit, sa, sb;
    logic                 b_zero, ovf_case;
    logic [MAX_WIDTH-1:0] a_mag32, b_mag32, q_fix32, r_fix32;
    logic                 unused_bits;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    assign b_zero   = (divisor == '0);
    assign ovf_case = signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);

    assign a_mag32 = twos_mag(MAX_WIDTH'(dividend), signed_mode & dividend[WIDTH-1]);
    assign b_mag32 = twos_mag(MAX_WIDTH'(divisor), signed_mode & divisor[WIDTH-1]);
    assign q_fix32 = twos_mag(MAX_WIDTH'(dq), sa ^ sb);
    assign r_fix32 = twos_mag(MAX_WIDTH'(p[WIDTH-1:0]), sa);

    assign unused_bits = ^{a_mag32, b_mag32, q_fix32, r_fix32, p[WIDTH]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p),
        .dbit   (dq[WIDTH-1]),
        .b      (b_mag),
        .p_next (p_step),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (b_zero || ovf_case) ? DONE : CALC;
            CALC:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // dq starts as |A| and fills with quotient bits from the LSB as A's bits shift out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            p           <= '0;
            dq          <= '0;
            b_mag       <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sa    <= signed_mode & dividend[WIDTH-1];
                    sb    <= signed_mode & divisor[WIDTH-1];
                    p     <= '0;
                    dq    <= a_mag32[WIDTH-1:0];
                    b_mag <= b_mag32[WIDTH-1:0];
                    cnt   <= CW'(WIDTH-1);
                    if (b_zero) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (ovf_case) begin
                        quotient  <= dividend;
                        remainder <= '0;
                        overflow  <= 1'b1;
                    end
                end
                CALC: begin
                    p  <= p_step;
                    dq <= {dq[WIDTH-2:0], q_bit};
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                FIX: begin
                    quotient  <= q_fix32[WIDTH-1:0];
                    remainder <= r_fix32[WIDTH-1:0];
                end
                DONE: if (out_ready) begin
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH=8) with handshake, reset and sweep checks.
module tb_seq_divider;
    import div_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [7:0] dividend, divisor, quotient, remainder;
    logic       div_by_zero, overflow;
    div_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         edge_idx;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_out_valid(output int idx);
        idx = 0;
        while (!out_valid && idx < 50) begin
            @(posedge clk); #1;
            idx++;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov, input int eidx, input string tag);
        int n;
        int idx;
        logic [17:0] e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        dividend = a; divisor = b; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 8'($urandom_range(0, 255));
        divisor  = 8'($urandom_range(0, 255));
        exp_q.push_back({eq, er, edz, eov});
        wait_out_valid(idx);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_latency"}, idx, eidx);
        e = exp_q.pop_front();
        check({tag, "_q"}, quotient, e[17:10]);
        check({tag, "_r"}, remainder, e[9:2]);
        check({tag, "_dz"}, div_by_zero, e[1]);
        check({tag, "_ov"}, overflow, e[0]);
        out_ready = 1'b1;
        #1;
        check({tag, "_busy_in_done"}, in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_released"}, {out_valid, in_ready, div_by_zero, overflow}, 4'b0100);
    endtask

    initial begin
        int idx;
        logic [7:0] ra, rb, eq, er;
        logic rsm, edz, eov;
        int ia, ib, iq, ir;

        vecs[0]  = '{8'd100, 8'd7,   1'b0, 8'h0E, 8'h02, 1'b0, 1'b0, 9};
        vecs[1]  = '{8'h9C,  8'h07,  1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, 9};
        vecs[2]  = '{8'h64,  8'hF9,  1'b1, 8'hF2, 8'h02, 1'b0, 1'b0, 9};
        vecs[3]  = '{8'hC8,  8'h00,  1'b0, 8'hFF, 8'hC8, 1'b1, 1'b0, 0};
        vecs[4]  = '{8'h80,  8'hFF,  1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 0};
        vecs[5]  = '{8'hFF,  8'h10,  1'b0, 8'h0F, 8'h0F, 1'b0, 1'b0, 9};
        vecs[6]  = '{8'h07,  8'h64,  1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 9};
        vecs[7]  = '{8'h80,  8'hFF,  1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 9};
        vecs[8]  = '{8'h9C,  8'hF9,  1'b1, 8'h0E, 8'hFE, 1'b0, 1'b0, 9};
        vecs[9]  = '{8'h00,  8'h00,  1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 0};
        vecs[10] = '{8'hFF,  8'h01,  1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
        vecs[11] = '{8'h80,  8'h01,  1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 9};
        vecs[12] = '{8'h7F,  8'h80,  1'b1, 8'h00, 8'h7F, 1'b0, 1'b0, 9};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; signed_mode = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_q", quotient, 0);
        check("reset_r", remainder, 0);
        check("reset_flags", {div_by_zero, overflow}, 0);
        check("reset_state", dbg_state, IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].q, vecs[i].r,
                   vecs[i].dz, vecs[i].ov, vecs[i].edge_idx, $sformatf("vec%0d", i));

        // Backpressure: hold DONE while the inputs churn.
        dividend = 8'd100; divisor = 8'd7; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out_valid(idx);
        check("bp_latency", idx, 9);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            dividend = 8'($urandom_range(0, 255));
            divisor  = 8'($urandom_range(1, 255));
            signed_mode = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("bp_q", quotient, 8'h0E);
            check("bp_r", remainder, 8'h02);
            check("bp_hold", {out_valid, in_ready}, 2'b10);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_idle", {out_valid, in_ready}, 2'b01);
        check("bp_state", dbg_state, IDLE);
        run_op(8'd255, 8'd16, 1'b0, 8'd15, 8'd15, 1'b0, 1'b0, 9, "bp_next");

        // Reset during the fourth CALC cycle.
        dividend = 8'd200; divisor = 8'd3; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("calc_state", dbg_state, CALC);
        rst = 1'b1;
        #1;
        check("rst_calc_hs", {out_valid, in_ready}, 2'b01);
        check("rst_calc_q", quotient, 0);
        check("rst_calc_r", remainder, 0);
        check("rst_calc_state", dbg_state, IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(8'd255, 8'd16, 1'b0, 8'd15, 8'd15, 1'b0, 1'b0, 9, "after_rst");

        // Reset while a divide-by-zero result is held.
        dividend = 8'd200; divisor = 8'd0; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("dz_held", {out_valid, div_by_zero}, 2'b11);
        rst = 1'b1;
        #1;
        check("rst_done", {out_valid, in_ready, div_by_zero, overflow}, 4'b0100);
        check("rst_done_r", remainder, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Random sweep against native integer division.
        for (int k = 0; k < 30; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (k % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            rsm = 1'($urandom_range(0, 1));
            if (k == 5) begin ra = 8'h80; rb = 8'hFF; rsm = 1'b1; end
            edz = 1'b0; eov = 1'b0;
            ia = rsm ? int'($signed(ra)) : int'(ra);
            ib = rsm ? int'($signed(rb)) : int'(rb);
            if (rb == 8'h00) begin
                eq = 8'hFF; er = ra; edz = 1'b1;
            end else if (rsm && ra == 8'h80 && rb == 8'hFF) begin
                eq = 8'h80; er = 8'h00; eov = 1'b1;
            end else begin
                eq = 8'(ia / ib); er = 8'(ia % ib);
            end
            run_op(ra, rb, rsm, eq, er, edz, eov, (edz || eov) ? 0 : 9, $sformatf("rnd%0d", k));
            if (!edz && !eov) begin
                iq = rsm ? int'($signed(quotient)) : int'(quotient);
                ir = rsm ? int'($signed(remainder)) : int'(remainder);
                check("rnd_identity", iq * ib + ir, ia);
                check("rnd_rem_mag", ((ir < 0 ? -ir : ir) < (ib < 0 ? -ib : ib)), 1);
                check("rnd_rem_sign", (ir == 0) || ((ir < 0) == (ia < 0)), 1);
            end
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
